ppd_commutator: RTL and testbench

//  Input commutator for the polyphase decimation filter. Collects gp_decimation_factor

---
 rtl/ppd_commutator.sv | 83 ++++++++
 tb/tb_ppd_commutator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ppd_commutator.sv
// rtl/ppd_commutator.sv - serial-to-frame commutator for the polyphase decimator.
// Packs D signed samples into one frame and strobes it to the multiply/add stage.
module ppd_commutator #(
  parameter int gp_idata_width       = 8,
  parameter int gp_decimation_factor = 4,
  parameter bit gp_ccw               = 1'b1,
  localparam int CW = (gp_decimation_factor > 1) ? $clog2(gp_decimation_factor) : 1
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_vld,
  input  logic                                         i_sync,
  input  logic [gp_idata_width-1:0]                    i_data,
  output logic                                         o_vld,
  output logic [gp_decimation_factor*gp_idata_width-1:0] o_data,
  output logic [CW-1:0]                                o_phase,
  output logic                                         o_drop
);

  localparam int W  = gp_idata_width;
  localparam int D  = gp_decimation_factor;
  localparam int FW = D * W;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] buf_q, buf_d;
  logic [FW-1:0] data_q, data_d;
  logic          vld_q, vld_d;
  logic          drop_q, drop_d;

  logic [CW-1:0] k;
  int            lane;

  always_comb begin
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    data_d = data_q;
    vld_d  = 1'b0;
    drop_d = 1'b0;
    // A realign forces the incoming sample to be the first of a new frame.
    k      = i_sync ? '0 : cnt_q;
    lane   = gp_ccw ? (D - 1 - int'(k)) : int'(k);

    if (i_sync) begin
      drop_d = (cnt_q != '0);
    end

    if (i_vld) begin
      buf_d[lane*W +: W] = i_data;
      if (k == LAST) begin
        data_d = buf_d;
        vld_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d  = k + CW'(1);
      end
    end else if (i_sync) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

  assign o_vld   = vld_q;
  assign o_data  = data_q;
  assign o_phase = cnt_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_ppd_commutator.sv
// tb/tb_ppd_commutator.sv - directed bench for ppd_commutator.
// Three instances share one stimulus stream: ccw D=4, cw D=4, and D=1.
module tb_ppd_commutator;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        sync;
  logic [7:0]  din;

  logic        a_vld, b_vld, c_vld;
  logic [31:0] a_data, b_data;
  logic [7:0]  c_data;
  logic [1:0]  a_phase, b_phase;
  logic [0:0]  c_phase;
  logic        a_drop, b_drop, c_drop;

  int passed = 0;
  int total  = 0;
  int pulses;

  always #5 clk = ~clk;

  ppd_commutator #(.gp_idata_width(8), .gp_decimation_factor(4), .gp_ccw(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_sync(sync), .i_data(din),
    .o_vld(a_vld), .o_data(a_data), .o_phase(a_phase), .o_drop(a_drop)
  );

  ppd_commutator #(.gp_idata_width(8), .gp_decimation_factor(4), .gp_ccw(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_sync(sync), .i_data(din),
    .o_vld(b_vld), .o_data(b_data), .o_phase(b_phase), .o_drop(b_drop)
  );

  ppd_commutator #(.gp_idata_width(8), .gp_decimation_factor(1), .gp_ccw(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_sync(sync), .i_data(din),
    .o_vld(c_vld), .o_data(c_data), .o_phase(c_phase), .o_drop(c_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs, let the rising edge pass, return at the falling edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    vld  = v;
    sync = s;
    din  = d;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sync = 1'b0; din = 8'h00;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h55);
    chk("rst_a_vld",   32'(a_vld),   32'h0);
    chk("rst_a_data",  a_data,       32'h0);
    chk("rst_a_phase", 32'(a_phase), 32'h0);
    chk("rst_a_drop",  32'(a_drop),  32'h0);
    chk("rst_c_data",  32'(c_data),  32'h0);
    rst = 1'b0;

    // ccw frame 1,2,3,4
    step(1'b1, 1'b0, 8'h01);
    chk("t1_phase1", 32'(a_phase), 32'd1);
    chk("t1_novld",  32'(a_vld),   32'h0);
    chk("t6_vld",    32'(c_vld),   32'h1);
    chk("t6_data",   32'(c_data),  32'h01);
    step(1'b1, 1'b0, 8'h02);
    chk("t1_phase2", 32'(a_phase), 32'd2);
    step(1'b1, 1'b0, 8'h03);
    chk("t1_phase3", 32'(a_phase), 32'd3);
    step(1'b1, 1'b0, 8'h04);
    chk("t1_vld",    32'(a_vld),   32'h1);
    chk("t1_data",   a_data,       32'h01020304);
    chk("t1_phase0", 32'(a_phase), 32'd0);
    chk("t2_b_data1", b_data,      32'h04030201);
    chk("t6_data4",  32'(c_data),  32'h04);
    chk("t6_phase",  32'(c_phase), 32'h0);

    // signed extremes, cw lane order
    step(1'b1, 1'b0, 8'h81);
    chk("t1_vld_once", 32'(a_vld), 32'h0);
    step(1'b1, 1'b0, 8'h7F);
    step(1'b1, 1'b0, 8'h00);
    chk("t2_b_hold", b_data, 32'h04030201);
    step(1'b1, 1'b0, 8'hFF);
    chk("t2_b_vld",  32'(b_vld), 32'h1);
    chk("t2_b_data", b_data,     32'hFF007F81);
    chk("t2_a_data", a_data,     32'h817F00FF);
    step(1'b0, 1'b0, 8'hAA);
    step(1'b0, 1'b0, 8'hBB);
    chk("t2_b_idle_vld", 32'(b_vld), 32'h0);
    chk("t2_b_stable",   b_data,     32'hFF007F81);
    chk("t2_b_phase",    32'(b_phase), 32'h0);

    // valid every 3rd cycle
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h20 + i));
      if (a_vld) pulses++;
      chk($sformatf("t3_vld_%0d", i), 32'(a_vld), (i == 3 || i == 7) ? 32'h1 : 32'h0);
      for (int j = 0; j < 2; j++) begin
        step(1'b0, 1'b0, 8'hEE);
        if (a_vld) pulses++;
      end
    end
    chk("t3_pulses", 32'(pulses), 32'd2);
    chk("t3_data",   a_data,      32'h24252627);

    // realign with a sample after a partial frame
    step(1'b1, 1'b0, 8'h31);
    step(1'b1, 1'b0, 8'h32);
    step(1'b1, 1'b1, 8'h10);
    chk("t4_drop",     32'(a_drop),  32'h1);
    chk("t4_phase",    32'(a_phase), 32'd1);
    chk("t4_novld",    32'(a_vld),   32'h0);
    chk("t4_data_kept", a_data,      32'h24252627);
    chk("t6_sync_vld", 32'(c_vld),   32'h1);
    chk("t6_sync_drop", 32'(c_drop), 32'h0);
    chk("t6_sync_data", 32'(c_data), 32'h10);
    step(1'b1, 1'b0, 8'h41);
    chk("t4_drop_once", 32'(a_drop), 32'h0);
    step(1'b1, 1'b0, 8'h42);
    chk("t4_no_partial_vld", 32'(a_vld), 32'h0);
    step(1'b1, 1'b0, 8'h43);
    chk("t4_vld",    32'(a_vld), 32'h1);
    chk("t4_a_data", a_data,     32'h10414243);
    chk("t4_b_data", b_data,     32'h43424110);

    // realign without a sample, then realign at a frame boundary
    step(1'b1, 1'b0, 8'h50);
    step(1'b0, 1'b1, 8'h00);
    chk("t4b_drop",  32'(a_drop),  32'h1);
    chk("t4b_phase", 32'(a_phase), 32'd0);
    step(1'b1, 1'b1, 8'h60);
    chk("t4c_nodrop", 32'(a_drop),  32'h0);
    chk("t4c_phase",  32'(a_phase), 32'd1);
    step(1'b1, 1'b0, 8'h61);
    step(1'b1, 1'b0, 8'h62);
    step(1'b1, 1'b0, 8'h63);
    chk("t4c_vld",  32'(a_vld), 32'h1);
    chk("t4c_data", a_data,     32'h60616263);

    // reset mid-frame
    step(1'b1, 1'b0, 8'h70);
    step(1'b1, 1'b0, 8'h71);
    chk("t5_pre_phase", 32'(a_phase), 32'd2);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h72);
    rst = 1'b0;
    chk("t5_data",  a_data,        32'h0);
    chk("t5_vld",   32'(a_vld),    32'h0);
    chk("t5_drop",  32'(a_drop),   32'h0);
    chk("t5_phase", 32'(a_phase),  32'd0);
    step(1'b1, 1'b0, 8'h80);
    step(1'b1, 1'b0, 8'h81);
    step(1'b1, 1'b0, 8'h82);
    chk("t5_novld", 32'(a_vld), 32'h0);
    step(1'b1, 1'b0, 8'h83);
    chk("t5_vld",      32'(a_vld),  32'h1);
    chk("t5_frame",    a_data,      32'h80818283);
    chk("t5_b_frame",  b_data,      32'h83828180);
    chk("t6_last",     32'(c_data), 32'h83);
    chk("t6_phase_end", 32'(c_phase), 32'h0);

    step(1'b0, 1'b0, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
